// File: rtl/dkong_audio_out.sv
// Audio output conditioning for the Donkey Kong sound board mix.
// Decimates the mix to one sample per CLOCKS_PER_SAMPLE clocks, optionally removes DC,
// applies a click-free gain ramp for mute/unmute and emits one sample with a valid pulse.
//
// Gain ramp states:
//   state        | meaning
//   ST_MUTED     | gain == 0, output silent
//   ST_RAMP_UP   | fading in, gain rises by RAMP_STEP per sample
//   ST_UNITY     | gain == 256, output passes unattenuated
//   ST_RAMP_DOWN | fading out, gain falls by RAMP_STEP per sample
module dkong_audio_out #(
    parameter int CLOCKS_PER_SAMPLE = 512,
    parameter int DC_SHIFT_K        = 8,
    parameter int RAMP_STEP         = 16
) (
    input  logic               W_CLK_24576M,
    input  logic               W_RESET,
    input  logic signed [15:0] I_SOUND_DAT,
    input  logic               I_DCBLOCK_EN,
    input  logic               I_MUTE,
    output logic signed [15:0] O_SOUND_DAT,
    output logic               O_SAMPLE_VALID,
    output logic               O_MUTED
);

    localparam logic [9:0]         LP_CNT_LAST = 10'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [8:0]         LP_STEP     = 9'(RAMP_STEP);
    localparam logic [8:0]         LP_UNITY    = 9'd256;
    localparam logic signed [25:0] LP_Y_MAX    = 26'sd8388607;
    localparam logic signed [25:0] LP_Y_MIN    = -26'sd8388608;
    localparam logic signed [25:0] LP_O_MAX    = 26'sd32767;
    localparam logic signed [25:0] LP_O_MIN    = -26'sd32768;

    typedef enum logic [1:0] {
        ST_MUTED     = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_UNITY     = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    logic [9:0]         r_cnt;
    logic               w_strobe;

    logic signed [15:0] r_x;
    logic signed [15:0] r_x_prev;
    logic signed [16:0] r_d;
    logic               r_mute;
    logic               r_v1;

    logic signed [23:0] r_y;
    logic signed [15:0] r_yo;
    logic               r_v2;
    logic signed [25:0] w_y_sum;
    logic signed [23:0] w_y_new;

    state_t             r_state;
    state_t             w_state_next;
    logic [8:0]         r_gain;
    logic [8:0]         w_gain_next;
    logic [8:0]         w_gain_up;
    logic [8:0]         w_gain_dn;
    logic               r_muted;

    logic signed [25:0] w_prod;
    logic signed [25:0] w_prod_sh;
    logic signed [15:0] w_out;

    assign w_strobe = (r_cnt == LP_CNT_LAST);

    // Sample-rate counter: wraps on the strobe cycle
    always_ff @(posedge W_CLK_24576M) begin
        if (W_RESET) begin
            r_cnt <= '0;
        end else if (w_strobe) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 10'd1;
        end
    end

    // S1: capture the mix and mute request, form the first difference
    always_ff @(posedge W_CLK_24576M) begin
        if (W_RESET) begin
            r_x      <= '0;
            r_x_prev <= '0;
            r_d      <= '0;
            r_mute   <= 1'b0;
            r_v1     <= 1'b0;
        end else begin
            r_v1 <= w_strobe;
            if (w_strobe) begin
                r_x      <= I_SOUND_DAT;
                r_x_prev <= I_SOUND_DAT;
                r_d      <= {I_SOUND_DAT[15], I_SOUND_DAT} - {r_x_prev[15], r_x_prev};
                r_mute   <= I_MUTE;
            end
        end
    end

    // DC blocker update at 26 bits, then clamped back into the 24-bit accumulator range
    always_comb begin
        w_y_sum = {{2{r_y[23]}}, r_y} - {{2{r_y[23]}}, (r_y >>> DC_SHIFT_K)} + {r_d[16], r_d, 8'h00};
        if (w_y_sum > LP_Y_MAX) begin
            w_y_new = 24'sh7FFFFF;
        end else if (w_y_sum < LP_Y_MIN) begin
            w_y_new = 24'sh800000;
        end else begin
            w_y_new = w_y_sum[23:0];
        end
    end

    // S2: DC blocker (or bypass, which also clears the accumulator for a clean re-enable)
    always_ff @(posedge W_CLK_24576M) begin
        if (W_RESET) begin
            r_y  <= '0;
            r_yo <= '0;
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                if (I_DCBLOCK_EN) begin
                    r_y  <= w_y_new;
                    r_yo <= w_y_new[23:8];
                end else begin
                    r_y  <= '0;
                    r_yo <= r_x;
                end
            end
        end
    end

    // Gain ramp state register; advances once per sample alongside S2
    always_ff @(posedge W_CLK_24576M) begin
        if (W_RESET) begin
            r_state <= ST_MUTED;
            r_gain  <= '0;
            r_muted <= 1'b1;
        end else if (r_v1) begin
            r_state <= w_state_next;
            r_gain  <= w_gain_next;
            r_muted <= (w_gain_next == 9'd0);
        end
    end

    // Gain ramp next state; direction follows the mute request, saturating at 0 and unity
    always_comb begin
        w_state_next = r_state;
        w_gain_next  = r_gain;
        w_gain_up    = (r_gain >= (LP_UNITY - LP_STEP)) ? LP_UNITY : (r_gain + LP_STEP);
        w_gain_dn    = (r_gain <= LP_STEP) ? 9'd0 : (r_gain - LP_STEP);
        case (r_state)
            ST_MUTED: begin
                if (!r_mute) begin
                    w_gain_next  = w_gain_up;
                    w_state_next = (w_gain_up == LP_UNITY) ? ST_UNITY : ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (r_mute) begin
                    w_gain_next  = w_gain_dn;
                    w_state_next = (w_gain_dn == 9'd0) ? ST_MUTED : ST_RAMP_DOWN;
                end else begin
                    w_gain_next  = w_gain_up;
                    w_state_next = (w_gain_up == LP_UNITY) ? ST_UNITY : ST_RAMP_UP;
                end
            end
            ST_UNITY: begin
                if (r_mute) begin
                    w_gain_next  = w_gain_dn;
                    w_state_next = (w_gain_dn == 9'd0) ? ST_MUTED : ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (!r_mute) begin
                    w_gain_next  = w_gain_up;
                    w_state_next = (w_gain_up == LP_UNITY) ? ST_UNITY : ST_RAMP_UP;
                end else begin
                    w_gain_next  = w_gain_dn;
                    w_state_next = (w_gain_dn == 9'd0) ? ST_MUTED : ST_RAMP_DOWN;
                end
            end
            default: begin
                w_state_next = ST_MUTED;
                w_gain_next  = '0;
            end
        endcase
    end

    // Gain multiply; gain is unsigned 0..256 so it is zero-extended before the signed product
    always_comb begin
        w_prod    = r_yo * $signed({1'b0, r_gain});
        w_prod_sh = w_prod >>> 8;
        if (w_prod_sh > LP_O_MAX) begin
            w_out = 16'sh7FFF;
        end else if (w_prod_sh < LP_O_MIN) begin
            w_out = 16'sh8000;
        end else begin
            w_out = w_prod_sh[15:0];
        end
    end

    // S3: present the scaled sample with a one-cycle valid pulse; data holds between pulses
    always_ff @(posedge W_CLK_24576M) begin
        if (W_RESET) begin
            O_SOUND_DAT    <= '0;
            O_SAMPLE_VALID <= 1'b0;
        end else begin
            O_SAMPLE_VALID <= r_v2;
            if (r_v2) begin
                O_SOUND_DAT <= w_out;
            end
        end
    end

    assign O_MUTED = r_muted;

endmodule

// File: tb/tb_dkong_audio_out.sv
// Self-checking bench for dkong_audio_out: per-cycle comparison against a sample-level
// arithmetic model, plus directed scenarios pinned with hand-computed values.
module tb_dkong_audio_out;

    localparam int CPS  = 512;
    localparam int K    = 8;
    localparam int STEP = 16;

    logic        clk          = 1'b0;
    logic        W_RESET      = 1'b1;
    logic [15:0] I_SOUND_DAT  = 16'h0000;
    logic        I_DCBLOCK_EN = 1'b0;
    logic        I_MUTE       = 1'b0;
    wire  [15:0] O_SOUND_DAT;
    wire         O_SAMPLE_VALID;
    wire         O_MUTED;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dkong_audio_out #(
        .CLOCKS_PER_SAMPLE(CPS),
        .DC_SHIFT_K       (K),
        .RAMP_STEP        (STEP)
    ) u_dut (
        .W_CLK_24576M  (clk),
        .W_RESET       (W_RESET),
        .I_SOUND_DAT   (I_SOUND_DAT),
        .I_DCBLOCK_EN  (I_DCBLOCK_EN),
        .I_MUTE        (I_MUTE),
        .O_SOUND_DAT   (O_SOUND_DAT),
        .O_SAMPLE_VALID(O_SAMPLE_VALID),
        .O_MUTED       (O_MUTED)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // cycle index since the last reset edge; cycle 0 is the first cycle out of reset
    int rel_cnt  = 0;
    bit rst_seen = 1'b0;
    always @(posedge clk) begin
        if (W_RESET) begin
            rel_cnt  = 0;
            rst_seen = 1'b1;
        end else begin
            rel_cnt++;
        end
    end

    // input data driver: either a held value or fresh random data every cycle
    bit          rand_mode = 1'b0;
    logic [15:0] dat_val   = 16'h0000;
    always @(posedge clk) begin
        #1;
        I_SOUND_DAT = rand_mode ? 16'($urandom) : dat_val;
    end

    // behavioural model state (one sample in flight at most)
    int m_xprev   = 0;
    int m_y       = 0;
    int m_gain    = 0;
    int exp_dat   = 0;
    bit exp_muted = 1'b1;
    bit exp_valid = 1'b0;
    bit pend_v    = 1'b0;
    int pend_s    = 0;
    int pend_d    = 0;
    bit pend_m    = 1'b0;
    int m_x, m_d, m_yo;

    always @(negedge clk) begin
        if (rst_seen) begin
            exp_valid = 1'b0;
            if (pend_v && rel_cnt == pend_s + 2) exp_muted = pend_m;
            if (pend_v && rel_cnt == pend_s + 3) begin
                exp_valid = 1'b1;
                exp_dat   = pend_d;
                pend_v    = 1'b0;
            end
            chk("valid", int'(O_SAMPLE_VALID), int'(exp_valid));
            chk("dat", int'($signed(O_SOUND_DAT)), exp_dat);
            chk("muted", int'(O_MUTED), int'(exp_muted));

            if (W_RESET) begin
                pend_v    = 1'b0;
                m_xprev   = 0;
                m_y       = 0;
                m_gain    = 0;
                exp_dat   = 0;
                exp_muted = 1'b1;
            end else if ((rel_cnt % CPS) == CPS - 1) begin
                m_x     = int'($signed(I_SOUND_DAT));
                m_d     = m_x - m_xprev;
                m_xprev = m_x;
                if (I_DCBLOCK_EN) begin
                    m_y = m_y - (m_y >>> K) + m_d * 256;
                    if (m_y > 8388607)  m_y = 8388607;
                    if (m_y < -8388608) m_y = -8388608;
                    m_yo = m_y >>> 8;
                end else begin
                    m_y  = 0;
                    m_yo = m_x;
                end
                if (I_MUTE) m_gain = (m_gain >= STEP) ? m_gain - STEP : 0;
                else        m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
                pend_d = (m_yo * m_gain) >>> 8;
                pend_m = (m_gain == 0);
                pend_s = rel_cnt;
                pend_v = 1'b1;
            end
        end
    end

    task automatic wait_valid(output int v, output int c);
        v = 0;
        c = -1;
        for (int i = 0; i < CPS + 600; i++) begin
            @(negedge clk);
            if (O_SAMPLE_VALID === 1'b1) begin
                v = int'($signed(O_SOUND_DAT));
                c = rel_cnt;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL timeout: no O_SAMPLE_VALID within %0d cycles", CPS + 600);
    endtask

    initial begin
        int v, c;
        bit found;

        W_RESET = 1'b1;
        repeat (3) @(posedge clk);
        #2 W_RESET = 1'b0;

        // fade-in through bypass
        I_DCBLOCK_EN = 1'b0;
        I_MUTE       = 1'b0;
        dat_val      = 16'h2000;
        for (int i = 1; i <= 18; i++) begin
            wait_valid(v, c);
            if (i == 1) begin
                chk("first_valid_cycle", c, 514);
                chk("fade_s1", v, 'h200);
                chk("fade_s1_muted", int'(O_MUTED), 0);
                @(negedge clk);
                chk("pulse_width", int'(O_SAMPLE_VALID), 0);
            end
            if (i == 2)  chk("fade_s2", v, 'h400);
            if (i == 16) chk("fade_s16", v, 'h2000);
            if (i == 17) chk("sample_period", c, 514 + 16 * CPS);
            if (i == 18) chk("fade_hold", v, 'h2000);
        end

        // DC blocker impulse-step response from a clean state
        dat_val = 16'h0000;
        wait_valid(v, c);
        chk("bypass_zero", v, 0);
        I_DCBLOCK_EN = 1'b1;
        dat_val      = 16'h1000;
        for (int i = 1; i <= 6; i++) begin
            wait_valid(v, c);
            if (i == 1) chk("dc_s1", v, 'h1000);
            if (i == 2) chk("dc_s2", v, 'h0FF0);
            if (i == 3) chk("dc_s3", v, 'h0FE0);
        end

        // full-scale step saturation
        I_DCBLOCK_EN = 1'b0;
        dat_val      = 16'h0000;
        wait_valid(v, c);
        I_DCBLOCK_EN = 1'b1;
        dat_val      = 16'h7FFF;
        for (int i = 1; i <= 4; i++) begin
            wait_valid(v, c);
            if (i == 1) chk("sat_pos", v, 32767);
        end
        dat_val = 16'h8000;
        wait_valid(v, c);
        chk("sat_neg", v, -32768);
        wait_valid(v, c);

        // mute ramp with reversals
        I_DCBLOCK_EN = 1'b0;
        dat_val      = 16'h4000;
        I_MUTE       = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            wait_valid(v, c);
            if (i == 8)  chk("mute_g128", v, 'h2000);
            if (i == 9)  chk("mute_g112", v, 'h1C00);
            if (i == 12) chk("mute_g64", v, 'h1000);
        end
        I_MUTE = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            wait_valid(v, c);
            if (i == 1) chk("unmute_g80", v, 'h1400);
            if (i == 2) chk("unmute_g96", v, 'h1800);
        end
        I_MUTE = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            wait_valid(v, c);
            if (i == 5) chk("remute_not_muted", int'(O_MUTED), 0);
            if (i == 6) begin
                chk("remute_zero", v, 0);
                chk("remute_muted", int'(O_MUTED), 1);
            end
        end

        // random data between and at strobes, random mute and blocker enable
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            I_MUTE       = ($urandom_range(0, 99) < 35);
            I_DCBLOCK_EN = $urandom_range(0, 1);
            wait_valid(v, c);
        end

        // reset between S1 and S3 discards the in-flight sample and restarts the fade
        rand_mode    = 1'b0;
        dat_val      = 16'h2000;
        I_DCBLOCK_EN = 1'b0;
        I_MUTE       = 1'b0;
        found        = 1'b0;
        for (int i = 0; i < CPS + 10; i++) begin
            @(negedge clk);
            if ((rel_cnt % CPS) == CPS - 1) begin
                found = 1'b1;
                break;
            end
        end
        chk("strobe_found", int'(found), 1);
        @(posedge clk);
        #2 W_RESET = 1'b1;
        @(posedge clk);
        #2 W_RESET = 1'b0;
        @(negedge clk);
        chk("rst_muted", int'(O_MUTED), 1);
        chk("rst_dat", int'($signed(O_SOUND_DAT)), 0);
        wait_valid(v, c);
        chk("rst_first_valid_cycle", c, 514);
        chk("rst_fade_s1", v, 'h200);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
